// File: rtl/simple_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : simple_pkg
//  Description : Shared SIMPLE ISA constants and helpers. Used by the control
//                path and by the instruction loader to recognise the halt
//                instruction.
//                FMT_ALU - format field value of ALU-class instructions
//                OP_HLT  - ALU opcode that halts the core
//                is_hlt  - 1 when a 16-bit word is the HLT instruction
//  Revision    : 1.0 - initial release
// ============================================================================
package simple_pkg;

  localparam logic [1:0] FMT_ALU = 2'b11;
  localparam logic [3:0] OP_HLT  = 4'b1111;

  // HLT is an ALU-format word (inst[15:14]) whose opcode (inst[7:4]) is all ones.
  function automatic logic is_hlt(input logic [15:0] inst);
    return (inst[15:14] == FMT_ALU) && (inst[7:4] == OP_HLT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
//  Module      : inst_loader
//  Description : Writer side of the instruction path. Packs pairs of incoming
//                bytes (first byte = inst[15:8]) into 16-bit words and writes
//                them to instruction memory from address 0, holding the core
//                in reset meanwhile. Stops after writing the first HLT word or
//                when the last address has been written (err=1).
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                start, abort        - begin a load / cancel a load (pulses)
//                rx_data/valid/ready - byte stream handshake
//                im_we/addr/wdata    - instruction memory write port
//                core_hold           - keep CPU in reset while loading
//                done, err           - load finished / memory filled w/o HLT
//                words_loaded        - words written in current/last load
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_loader
  import simple_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [15:0]       im_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HI   = 3'd1;
  localparam logic [2:0] S_LO   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [2:0]        state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        lo_q, lo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              rdy_q, rdy_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              w_xfer;
  logic              w_start;
  logic              w_busy;
  logic [15:0]       w_word;

  assign w_xfer  = rx_valid && rdy_q;
  assign w_start = start && !abort;          // abort wins over a coincident start
  assign w_busy  = (state_q == S_HI) || (state_q == S_LO) || (state_q == S_WR);
  assign w_word  = {hi_q, lo_q};

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (w_start) state_d = S_HI;
      S_HI: begin
        if (abort)       state_d = S_IDLE;
        else if (w_xfer) state_d = S_LO;
      end
      S_LO: begin
        if (abort)       state_d = S_IDLE;
        else if (w_xfer) state_d = S_WR;
      end
      S_WR: begin
        if (abort)                 state_d = S_IDLE;
        else if (is_hlt(w_word))   state_d = S_DONE;
        else if (addr_q == LAST_ADDR) state_d = S_DONE;
        else                       state_d = S_HI;
      end
      S_DONE: if (w_start) state_d = S_HI;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    addr_d = addr_q;
    cnt_d  = cnt_q;
    hold_d = hold_q;
    done_d = done_q;
    err_d  = err_q;
    im_we  = (state_q == S_WR);

    // ready is registered from the next state so it is high exactly in HI/LO
    rdy_d  = (state_d == S_HI) || (state_d == S_LO);

    if (((state_q == S_IDLE) || (state_q == S_DONE)) && w_start) begin
      addr_d = '0;
      cnt_d  = '0;
      err_d  = 1'b0;
      done_d = 1'b0;
      hold_d = 1'b1;
    end

    if ((state_q == S_HI) && w_xfer) hi_d = rx_data;
    if ((state_q == S_LO) && w_xfer) lo_d = rx_data;

    if (state_q == S_WR) begin
      // The write happens regardless of abort, so it is always counted
      cnt_d = cnt_q + 1'b1;
      if (!abort) begin
        if (is_hlt(w_word)) begin
          done_d = 1'b1;
          err_d  = 1'b0;
          hold_d = 1'b0;
        end else if (addr_q == LAST_ADDR) begin
          done_d = 1'b1;
          err_d  = 1'b1;
          hold_d = 1'b0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
    end

    if (w_busy && abort) begin
      hold_d = 1'b0;
      done_d = 1'b0;
    end
  end

  assign rx_ready     = rdy_q;
  assign im_addr      = addr_q;
  assign im_wdata     = w_word;
  assign core_hold    = hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_loader
//  Description : Self-checking bench for inst_loader. Expected memory writes
//                are queued by a word-level reference model when a load is
//                issued; a monitor pops and compares on every write strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_loader;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [15:0]       im_wdata;
  logic              core_hold;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  inst_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .core_hold    (core_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int          exp_addr_q[$];
  logic [15:0] exp_data_q[$];
  int          mon_addr;
  logic [15:0] mon_data;

  logic [15:0] ld_words[DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr=%0d data=0x%0h expected no write",
                 im_addr, im_wdata);
      end else begin
        mon_addr = exp_addr_q.pop_front();
        mon_data = exp_data_q.pop_front();
        chk("wr_addr", 32'(im_addr), 32'(mon_addr));
        chk("wr_data", 32'(im_wdata), 32'(mon_data));
      end
    end
  end

  function automatic bit ref_is_hlt(input logic [15:0] w);
    return ((w >> 14) == 16'd3) && (((w >> 4) & 16'hF) == 16'hF);
  endfunction

  task automatic expect_write(input int a, input logic [15:0] d);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(d);
  endtask

  task automatic pulse(input logic s, input logic a);
    @(negedge clk);
    start = s;
    abort = a;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    repeat (gap) begin
      @(negedge clk);
      rx_data = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (rx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL rx_ready_timeout: got rx_ready=%b expected 1 within 40 cycles", rx_ready);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    chk("done_reached", 32'(done), 32'd1);
  endtask

  // Full load of ld_words; the model decides how many words are consumed
  task automatic run_load(input int maxgap, input bit mid_start);
    int n;
    bit e;
    n = 0;
    e = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      expect_write(i, ld_words[i]);
      n = i + 1;
      if (ref_is_hlt(ld_words[i])) begin
        e = 1'b0;
        break;
      end
      e = (i == DEPTH - 1);
    end
    pulse(1'b1, 1'b0);
    chk("start_hold",  32'(core_hold), 32'd1);
    chk("start_done",  32'(done), 32'd0);
    chk("start_err",   32'(err), 32'd0);
    chk("start_count", 32'(words_loaded), 32'd0);
    chk("start_ready", 32'(rx_ready), 32'd1);
    chk("start_addr",  32'(im_addr), 32'd0);
    for (int i = 0; i < n; i++) begin
      send_byte(ld_words[i][15:8], int'($urandom_range(maxgap, 0)));
      if (mid_start && i == 0) pulse(1'b1, 1'b0);
      send_byte(ld_words[i][7:0], int'($urandom_range(maxgap, 0)));
    end
    wait_done();
    chk("end_err",     32'(err), 32'(e));
    chk("end_count",   32'(words_loaded), 32'(n));
    chk("end_hold",    32'(core_hold), 32'd0);
    @(negedge clk);
    chk("end_ready",   32'(rx_ready), 32'd0);
    chk("end_pending", 32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_we"},    32'(im_we), 32'd0);
    chk({tag, "_addr"},  32'(im_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(im_wdata), 32'd0);
    chk({tag, "_hold"},  32'(core_hold), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_err"},   32'(err), 32'd0);
    chk({tag, "_count"}, 32'(words_loaded), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst = 1'b0;

    // Two-word program ending in HLT
    ld_words = '{16'h0001, 16'hC0F0, 16'h0000, 16'h0000};
    run_load(0, 1'b0);

    // abort while DONE has no effect
    pulse(1'b0, 1'b1);
    chk("done_abort_done", 32'(done), 32'd1);
    chk("done_abort_hold", 32'(core_hold), 32'd0);

    // Memory fills without HLT
    ld_words = '{16'h1122, 16'h3344, 16'h5566, 16'h7788};
    run_load(0, 1'b0);

    // Restart from DONE clears err
    ld_words = '{16'h1234, 16'hC0F0, 16'h0000, 16'h0000};
    run_load(0, 1'b0);

    // Random valid gaps, plus an ignored start mid-load
    ld_words = '{16'h0001, 16'hC0F0, 16'h0000, 16'h0000};
    run_load(5, 1'b1);

    // Abort (with coincident start) after the first byte of word 2
    pulse(1'b1, 1'b0);
    expect_write(0, 16'h0001);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hC0, 0);
    pulse(1'b1, 1'b1);
    chk("abort_hold",  32'(core_hold), 32'd0);
    chk("abort_done",  32'(done), 32'd0);
    chk("abort_ready", 32'(rx_ready), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_idle_ready", 32'(rx_ready), 32'd0);
    chk("abort_pending", 32'(exp_addr_q.size()), 32'd0);
    ld_words = '{16'h1234, 16'hC0F0, 16'h0000, 16'h0000};
    run_load(2, 1'b0);

    // Reset while in LO of the second word
    pulse(1'b1, 1'b0);
    expect_write(0, 16'h1234);
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    send_byte(8'h56, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("midrst");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_idle_ready", 32'(rx_ready), 32'd0);
    chk("midrst_pending", 32'(exp_addr_q.size()), 32'd0);

    // Randomized loads, some with an HLT placed at a random slot
    for (int t = 0; t < 20; t++) begin
      int hslot;
      for (int i = 0; i < DEPTH; i++) ld_words[i] = 16'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        hslot = int'($urandom_range(DEPTH - 1, 0));
        ld_words[hslot] = {2'b11, 6'($urandom), 4'hF, 4'($urandom)};
      end
      run_load(3, ($urandom_range(3, 0) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
